// File: rtl/dram_request_queue.sv
// In-order request queue between the trace parser and the DRAM command scheduler.
// A circular buffer exposes its oldest entry along with a per-entry residency age.
module dram_request_queue #(
  parameter int unsigned QUEUE_SIZE    = 16,
  parameter int unsigned ADDRESS_WIDTH = 33,
  parameter int unsigned AGE_WIDTH     = 20
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_op_ready_s,
  input  logic [1:0]                   in_opcode,
  input  logic [ADDRESS_WIDTH-1:0]     in_address,
  input  logic [31:0]                  in_time_cpu,
  input  logic                         head_pop,
  output logic                         queue_full,
  output logic                         queue_empty,
  output logic [$clog2(QUEUE_SIZE):0]  occupancy,
  output logic                         head_valid,
  output logic [1:0]                   head_opcode,
  output logic [ADDRESS_WIDTH-1:0]     head_address,
  output logic [31:0]                  head_time_cpu,
  output logic [AGE_WIDTH-1:0]         head_age,
  output logic                         drop_error
);

  localparam int unsigned PtrW = $clog2(QUEUE_SIZE);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [1:0] OpNop = 2'd3;
  localparam logic [AGE_WIDTH-1:0] AgeMax = '1;

  logic [PtrW-1:0]          rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]          count_q, count_d;
  logic                     drop_error_q;
  logic [QUEUE_SIZE-1:0]    valid_q;
  logic [AGE_WIDTH-1:0]     age_q    [QUEUE_SIZE];
  logic [1:0]               opcode_q [QUEUE_SIZE];
  logic [ADDRESS_WIDTH-1:0] addr_q   [QUEUE_SIZE];
  logic [31:0]              time_q   [QUEUE_SIZE];

  logic is_full, is_empty, real_op, do_pop, do_push, overflow;

  always_comb begin
    is_full  = (count_q == CntW'(QUEUE_SIZE));
    is_empty = (count_q == '0);
    real_op  = in_op_ready_s && (in_opcode != OpNop);
    do_pop   = head_pop && !is_empty;
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    do_push  = real_op && (!is_full || do_pop);
    overflow = real_op && !do_push;
  end

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      drop_error_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (overflow) drop_error_q <= 1'b1;
    end
  end

  // Per-entry valid and age; a slot both popped and refilled this cycle restarts at age 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < QUEUE_SIZE; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        if (do_push && (wr_ptr_q == PtrW'(i))) begin
          valid_q[i] <= 1'b1;
          age_q[i]   <= '0;
        end else if (do_pop && (rd_ptr_q == PtrW'(i))) begin
          valid_q[i] <= 1'b0;
        end else if (valid_q[i] && (age_q[i] != AgeMax)) begin
          age_q[i] <= age_q[i] + AGE_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !reset) begin
      opcode_q[wr_ptr_q] <= in_opcode;
      addr_q[wr_ptr_q]   <= in_address;
      time_q[wr_ptr_q]   <= in_time_cpu;
    end
  end

  always_comb begin
    queue_full    = is_full;
    queue_empty   = is_empty;
    occupancy     = count_q;
    head_valid    = !is_empty;
    drop_error    = drop_error_q;
    head_opcode   = OpNop;
    head_address  = '0;
    head_time_cpu = '0;
    head_age      = '0;
    if (!is_empty) begin
      head_opcode   = opcode_q[rd_ptr_q];
      head_address  = addr_q[rd_ptr_q];
      head_time_cpu = time_q[rd_ptr_q];
      head_age      = age_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_dram_request_queue.sv
// Self-checking bench for dram_request_queue: vector table, scoreboard of pushed requests,
// and hand sequences for fill/overflow, full push+pop, pointer wrap, reset and age saturation.
module tb_dram_request_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_op_ready_s;
  logic [1:0]  in_opcode;
  logic [32:0] in_address;
  logic [31:0] in_time_cpu;
  logic        head_pop;
  logic        queue_full, queue_empty, head_valid, drop_error;
  logic [4:0]  occupancy;
  logic [1:0]  head_opcode;
  logic [32:0] head_address;
  logic [31:0] head_time_cpu;
  logic [19:0] head_age;

  // Narrow-age instance so saturation is reachable in a short run.
  logic        s_strobe, s_pop;
  logic        s_full, s_empty, s_head_valid, s_drop;
  logic [4:0]  s_occ;
  logic [1:0]  s_opcode;
  logic [32:0] s_address;
  logic [31:0] s_time;
  logic [7:0]  s_age;

  always #5 clock = ~clock;

  dram_request_queue dut (
    .clock(clock), .reset(reset), .in_op_ready_s(in_op_ready_s), .in_opcode(in_opcode),
    .in_address(in_address), .in_time_cpu(in_time_cpu), .head_pop(head_pop),
    .queue_full(queue_full), .queue_empty(queue_empty), .occupancy(occupancy),
    .head_valid(head_valid), .head_opcode(head_opcode), .head_address(head_address),
    .head_time_cpu(head_time_cpu), .head_age(head_age), .drop_error(drop_error)
  );

  dram_request_queue #(.AGE_WIDTH(8)) dut_sat (
    .clock(clock), .reset(reset), .in_op_ready_s(s_strobe), .in_opcode(2'd2),
    .in_address(33'h1_0F0F_0F0F), .in_time_cpu(32'd77), .head_pop(s_pop),
    .queue_full(s_full), .queue_empty(s_empty), .occupancy(s_occ),
    .head_valid(s_head_valid), .head_opcode(s_opcode), .head_address(s_address),
    .head_time_cpu(s_time), .head_age(s_age), .drop_error(s_drop)
  );

  typedef struct packed {
    logic [1:0]  op;
    logic [32:0] addr;
    logic [31:0] tm;
  } sb_t;

  typedef struct packed {
    logic        strobe;
    logic [1:0]  op;
    logic [32:0] addr;
    logic [31:0] tm;
    logic        pop;
    logic [4:0]  exp_occ;
    logic        exp_drop;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[8];
  bit   m_drop;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic strobe, input logic pop);
    reset = 1'b1;
    in_op_ready_s = strobe;
    in_opcode = 2'd0;
    in_address = 33'h0_5555_5555;
    in_time_cpu = 32'd99;
    head_pop = pop;
    @(posedge clock);
    #1;
    reset = 1'b0;
    in_op_ready_s = 1'b0;
    head_pop = 1'b0;
    sb.delete();
    m_drop = 1'b0;
  endtask

  task automatic check_reset_state();
    chk("rst_occupancy", 64'(occupancy), 0);
    chk("rst_empty", 64'(queue_empty), 1);
    chk("rst_full", 64'(queue_full), 0);
    chk("rst_head_valid", 64'(head_valid), 0);
    chk("rst_head_opcode", 64'(head_opcode), 3);
    chk("rst_head_address", 64'(head_address), 0);
    chk("rst_head_time", 64'(head_time_cpu), 0);
    chk("rst_head_age", 64'(head_age), 0);
    chk("rst_drop", 64'(drop_error), 0);
  endtask

  // One clock of stimulus; the scoreboard predicts acceptance and checks the head on pops.
  task automatic step(input logic s, input logic [1:0] op, input logic [32:0] a,
                      input logic [31:0] t, input logic p);
    bit  pop_ok, push_ok;
    sb_t e;
    pop_ok  = p && (sb.size() != 0);
    push_ok = s && (op != 2'd3) && ((sb.size() < 16) || pop_ok);
    if (p) begin
      if (pop_ok) begin
        e = sb.pop_front();
        chk("pop_head_valid", 64'(head_valid), 1);
        chk("pop_head_opcode", 64'(head_opcode), 64'(e.op));
        chk("pop_head_address", 64'(head_address), 64'(e.addr));
        chk("pop_head_time", 64'(head_time_cpu), 64'(e.tm));
      end else begin
        chk("pop_empty_opcode", 64'(head_opcode), 3);
        chk("pop_empty_valid", 64'(head_valid), 0);
      end
    end
    if (push_ok) sb.push_back('{op: op, addr: a, tm: t});
    else if (s && (op != 2'd3)) m_drop = 1'b1;
    in_op_ready_s = s;
    in_opcode = op;
    in_address = a;
    in_time_cpu = t;
    head_pop = p;
    @(posedge clock);
    #1;
    in_op_ready_s = 1'b0;
    head_pop = 1'b0;
    chk("occupancy", 64'(occupancy), 64'(sb.size()));
    chk("full", 64'(queue_full), 64'(sb.size() == 16));
    chk("empty", 64'(queue_empty), 64'(sb.size() == 0));
    chk("drop_error", 64'(drop_error), 64'(m_drop));
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 2'd0, 33'd0, 32'd0, 1'b0);
  endtask

  initial begin
    s_strobe = 1'b0;
    s_pop = 1'b0;
    vecs[0] = '{1'b1, 2'd0, 33'h1_0000_0000, 32'd1, 1'b0, 5'd1, 1'b0};
    vecs[1] = '{1'b1, 2'd3, 33'h0_0000_0BAD, 32'd2, 1'b0, 5'd1, 1'b0};
    vecs[2] = '{1'b1, 2'd1, 33'h0_ABCD_0000, 32'd3, 1'b1, 5'd1, 1'b0};
    vecs[3] = '{1'b1, 2'd2, 33'h1_FFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd2, 1'b0};
    vecs[4] = '{1'b0, 2'd0, 33'h0, 32'd0, 1'b1, 5'd1, 1'b0};
    vecs[5] = '{1'b0, 2'd0, 33'h0, 32'd0, 1'b1, 5'd0, 1'b0};
    vecs[6] = '{1'b0, 2'd0, 33'h0, 32'd0, 1'b1, 5'd0, 1'b0};
    vecs[7] = '{1'b1, 2'd3, 33'h0, 32'd0, 1'b1, 5'd0, 1'b0};

    do_reset(1'b0, 1'b0);
    check_reset_state();

    // First push reaches the head one cycle later, then ages one per clock.
    step(1'b1, 2'd0, 33'h1_2345_6780, 32'd10, 1'b0);
    chk("first_head_valid", 64'(head_valid), 1);
    chk("first_head_address", 64'(head_address), 64'h1_2345_6780);
    chk("first_head_time", 64'(head_time_cpu), 10);
    chk("first_head_age", 64'(head_age), 0);
    idle(5);
    chk("age_after_5", 64'(head_age), 5);
    idle(995);
    chk("age_after_1000", 64'(head_age), 1000);
    step(1'b0, 2'd0, 33'd0, 32'd0, 1'b1);

    // Vector table
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].strobe, vecs[i].op, vecs[i].addr, vecs[i].tm, vecs[i].pop);
      chk("vec_occupancy", 64'(occupancy), 64'(vecs[i].exp_occ));
      chk("vec_drop", 64'(drop_error), 64'(vecs[i].exp_drop));
    end

    // Fill, overflow, partial drain, then reset with push and pop asserted.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 2'(i % 3), 33'h100 + 33'(i), 32'(1000 + i), 1'b0);
    chk("fill_full", 64'(queue_full), 1);
    chk("fill_occupancy", 64'(occupancy), 16);
    step(1'b1, 2'd1, 33'h0_DEAD_BEEF, 32'd5000, 1'b0);
    chk("overflow_drop", 64'(drop_error), 1);
    chk("overflow_occupancy", 64'(occupancy), 16);
    for (int i = 0; i < 5; i++) step(1'b0, 2'd0, 33'd0, 32'd0, 1'b1);
    chk("drop_sticky", 64'(drop_error), 1);
    do_reset(1'b1, 1'b1);
    check_reset_state();

    // Full queue with simultaneous push and pop reuses the freed slot.
    for (int i = 0; i < 16; i++) step(1'b1, 2'd0, 33'h200 + 33'(i), 32'(i), 1'b0);
    step(1'b1, 2'd2, 33'h0_0000_0999, 32'd999, 1'b1);
    chk("full_pp_occupancy", 64'(occupancy), 16);
    chk("full_pp_drop", 64'(drop_error), 0);
    for (int i = 0; i < 15; i++) step(1'b0, 2'd0, 33'd0, 32'd0, 1'b1);
    chk("reused_entry_at_head", 64'(head_address), 64'h999);
    chk("reused_entry_age", 64'(head_age), 15);
    step(1'b0, 2'd0, 33'd0, 32'd0, 1'b1);

    // Pointer wrap with interleaved pops, then full drain.
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 2'(i % 3), 33'h2000 + 33'(i), 32'(i * 7), 1'(i % 2));
    chk("wrap_occupancy", 64'(occupancy), 10);
    while (sb.size() != 0) step(1'b0, 2'd0, 33'd0, 32'd0, 1'b1);
    step(1'b0, 2'd0, 33'd0, 32'd0, 1'b1);
    chk("wrap_drained_opcode", 64'(head_opcode), 3);

    // Age saturation on the narrow instance.
    s_strobe = 1'b1;
    @(posedge clock);
    #1;
    s_strobe = 1'b0;
    chk("sat_age_start", 64'(s_age), 0);
    repeat (200) @(posedge clock);
    #1;
    chk("sat_age_200", 64'(s_age), 200);
    repeat (300) @(posedge clock);
    #1;
    chk("sat_age_max", 64'(s_age), 255);
    chk("sat_occupancy", 64'(s_occ), 1);
    chk("sat_flags", 64'({s_full, s_empty, s_head_valid, s_drop}), 64'b0010);
    chk("sat_fields", 64'({s_opcode, s_address}), 64'({2'd2, 33'h1_0F0F_0F0F}));
    chk("sat_time", 64'(s_time), 77);
    s_pop = 1'b1;
    @(posedge clock);
    #1;
    s_pop = 1'b0;
    chk("sat_popped_empty", 64'(s_empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
